// File: rtl/dense_layer_tm.sv
// Time-multiplexed fully-connected layer: NUM_MACS lanes sweep the neurons group by
// group, streaming one weight per lane per cycle from synchronous external memories.
module dense_layer_tm #(
  parameter int    DATA_WIDTH  = 16,
  parameter int    FRAC_BITS   = 8,
  parameter int    NUM_INPUTS  = 16,
  parameter int    NUM_NEURONS = 16,
  parameter int    NUM_MACS    = 4,
  parameter string ACTIVATION  = "RELU",
  localparam int   GROUPS      = NUM_NEURONS / NUM_MACS,
  localparam int   WA_W        = (GROUPS * NUM_INPUTS > 1) ? $clog2(GROUPS * NUM_INPUTS) : 1,
  localparam int   BA_W        = (GROUPS > 1) ? $clog2(GROUPS) : 1
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0]  inputs,
  output logic [WA_W-1:0]                       weight_addr,
  input  logic [NUM_MACS-1:0][DATA_WIDTH-1:0]    weight_data,
  output logic [BA_W-1:0]                       bias_addr,
  input  logic [NUM_MACS-1:0][DATA_WIDTH-1:0]    bias_data,
  output logic [NUM_NEURONS-1:0][DATA_WIDTH-1:0] outputs,
  output logic                                  out_valid,
  input  logic                                  out_ready
);

  localparam int ACC_W = 2 * DATA_WIDTH + $clog2(NUM_INPUTS + 1);
  localparam int CW    = $clog2(NUM_INPUTS + 2);
  localparam int GW    = BA_W;
  localparam bit USE_RELU = (ACTIVATION == "RELU");

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COMPUTE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  localparam logic [CW-1:0] C_ZERO = CW'(0);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] C_N    = CW'(NUM_INPUTS);
  localparam logic [CW-1:0] C_LAST = CW'(NUM_INPUTS + 1);
  localparam logic [GW-1:0] G_LAST = GW'(GROUPS - 1);

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

  logic [1:0]                             state_q, state_d;
  logic [GW-1:0]                          grp_q, grp_d;
  logic [CW-1:0]                          cyc_q, cyc_d;
  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0]  in_vec_q, in_vec_d;
  logic signed [ACC_W-1:0]                acc_q [NUM_MACS];
  logic signed [ACC_W-1:0]                acc_d [NUM_MACS];
  logic [NUM_NEURONS-1:0][DATA_WIDTH-1:0] out_q, out_d;
  logic                                   out_valid_q, out_valid_d;
  logic                                   in_ready_q, in_ready_d;
  logic [WA_W-1:0]                        weight_addr_q, weight_addr_d;
  logic [BA_W-1:0]                        bias_addr_q, bias_addr_d;

  logic signed [DATA_WIDTH-1:0]   x_sel_s;
  logic signed [2*DATA_WIDTH-1:0] prod_s     [NUM_MACS];
  logic signed [ACC_W-1:0]        prod_ext_s [NUM_MACS];
  logic signed [ACC_W-1:0]        bias_ext_s [NUM_MACS];

  // Scale back to the output format, clamp, then apply the activation.
  function automatic logic [DATA_WIDTH-1:0] sat_act(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    logic [DATA_WIDTH-1:0]   r;
    s = a >>> FRAC_BITS;
    if (s > SAT_MAX) begin
      r = SAT_MAX[DATA_WIDTH-1:0];
    end else if (s < SAT_MIN) begin
      r = SAT_MIN[DATA_WIDTH-1:0];
    end else begin
      r = s[DATA_WIDTH-1:0];
    end
    return (USE_RELU && r[DATA_WIDTH-1]) ? {DATA_WIDTH{1'b0}} : r;
  endfunction

  // Sequencer: idle/compute/done handshake and group/cycle counters.
  always_comb begin
    state_d     = state_q;
    grp_d       = grp_q;
    cyc_d       = cyc_q;
    in_vec_d    = in_vec_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          in_vec_d = inputs;
          state_d  = ST_COMPUTE;
          grp_d    = '0;
          cyc_d    = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COMPUTE: begin
        if (cyc_q == C_LAST) begin
          cyc_d = '0;
          if (grp_q == G_LAST) begin
            state_d     = ST_DONE;
            grp_d       = '0;
            out_valid_d = 1'b1;
          end else begin
            grp_d = grp_q + 1'b1;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
    in_ready_d = (state_d == ST_IDLE);
  end

  // MAC lanes: bias-seeded accumulation, then result write-back in the last group cycle.
  always_comb begin
    acc_d   = acc_q;
    out_d   = out_q;
    x_sel_s = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      x_sel_s = x_sel_s | ({DATA_WIDTH{cyc_q == CW'(i + 1)}} & in_vec_q[i]);
    end
    for (int m = 0; m < NUM_MACS; m++) begin
      prod_s[m]     = x_sel_s * $signed(weight_data[m]);
      prod_ext_s[m] = {{(ACC_W - 2 * DATA_WIDTH){prod_s[m][2*DATA_WIDTH-1]}}, prod_s[m]};
      bias_ext_s[m] = {{(ACC_W - DATA_WIDTH){bias_data[m][DATA_WIDTH-1]}}, bias_data[m]} <<< FRAC_BITS;
    end
    if (state_q == ST_COMPUTE && cyc_q != C_ZERO && cyc_q != C_LAST) begin
      for (int m = 0; m < NUM_MACS; m++) begin
        acc_d[m] = ((cyc_q == C_ONE) ? bias_ext_s[m] : acc_q[m]) + prod_ext_s[m];
      end
    end else if (state_q == ST_COMPUTE && cyc_q == C_LAST) begin
      for (int gi = 0; gi < GROUPS; gi++) begin
        for (int m = 0; m < NUM_MACS; m++) begin
          out_d[gi*NUM_MACS+m] = (grp_q == GW'(gi)) ? sat_act(acc_q[m]) : out_q[gi*NUM_MACS+m];
        end
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // Addresses are registered from next-state so they line up with the group cycle they serve.
  always_comb begin
    weight_addr_d = '0;
    bias_addr_d   = '0;
    if (state_d == ST_COMPUTE) begin
      bias_addr_d   = BA_W'(grp_d);
      weight_addr_d = (cyc_d < C_N) ? (WA_W'(grp_d) * WA_W'(NUM_INPUTS) + WA_W'(cyc_d)) : '0;
    end else begin
      bias_addr_d   = '0;
      weight_addr_d = '0;
    end
  end

  // State and registered outputs; reset aborts any transaction in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      grp_q         <= '0;
      cyc_q         <= '0;
      in_vec_q      <= '0;
      out_q         <= '0;
      out_valid_q   <= 1'b0;
      in_ready_q    <= 1'b1;
      weight_addr_q <= '0;
      bias_addr_q   <= '0;
      for (int m = 0; m < NUM_MACS; m++) begin
        acc_q[m] <= '0;
      end
    end else begin
      state_q       <= state_d;
      grp_q         <= grp_d;
      cyc_q         <= cyc_d;
      in_vec_q      <= in_vec_d;
      out_q         <= out_d;
      out_valid_q   <= out_valid_d;
      in_ready_q    <= in_ready_d;
      weight_addr_q <= weight_addr_d;
      bias_addr_q   <= bias_addr_d;
      for (int m = 0; m < NUM_MACS; m++) begin
        acc_q[m] <= acc_d[m];
      end
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign outputs     = out_q;
  assign weight_addr = weight_addr_q;
  assign bias_addr   = bias_addr_q;

endmodule

// File: tb/tb_dense_layer_tm.sv
// Scoreboard bench for dense_layer_tm: RELU and IDENTITY instances run in lockstep on
// directed vectors; a negedge monitor checks each result against queued expectations.
module tb_dense_layer_tm;
  localparam int W = 16, F = 8, N = 4, NN = 4, M = 2, G = NN / M, LAT = G * (N + 2);

  typedef logic [NN-1:0][W-1:0] vec_t;
  typedef logic [N-1:0][W-1:0]  ivec_t;
  typedef struct packed { vec_t relu; vec_t id; } exp_t;

  logic clk = 1'b0;
  logic rst_n, in_valid, out_ready;
  ivec_t inputs;
  logic in_ready_r, in_ready_i, ov_r, ov_i;
  logic [2:0] wa_r, wa_i;
  logic [0:0] ba_r, ba_i;
  logic [M-1:0][W-1:0] wd_r, wd_i, bd_r, bd_i;
  vec_t outs_r, outs_i;

  logic signed [W-1:0] w_tab [NN][N];
  logic signed [W-1:0] b_tab [NN];

  int cyc = 0, total = 0, bad = 0;
  exp_t exp_q[$];
  int   acc_t_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dense_layer_tm #(.DATA_WIDTH(W), .FRAC_BITS(F), .NUM_INPUTS(N), .NUM_NEURONS(NN),
                   .NUM_MACS(M), .ACTIVATION("RELU")) dut_relu (
    .clock(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(in_ready_r), .inputs(inputs),
    .weight_addr(wa_r), .weight_data(wd_r), .bias_addr(ba_r), .bias_data(bd_r),
    .outputs(outs_r), .out_valid(ov_r), .out_ready(out_ready));

  dense_layer_tm #(.DATA_WIDTH(W), .FRAC_BITS(F), .NUM_INPUTS(N), .NUM_NEURONS(NN),
                   .NUM_MACS(M), .ACTIVATION("IDENTITY")) dut_id (
    .clock(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(in_ready_i), .inputs(inputs),
    .weight_addr(wa_i), .weight_data(wd_i), .bias_addr(ba_i), .bias_data(bd_i),
    .outputs(outs_i), .out_valid(ov_i), .out_ready(out_ready));

  function automatic logic [M-1:0][W-1:0] rd_w(input logic [2:0] a);
    logic [M-1:0][W-1:0] r;
    int g, i;
    g = int'(a) / N;
    i = int'(a) % N;
    for (int m = 0; m < M; m++) r[m] = w_tab[g*M+m][i];
    return r;
  endfunction

  function automatic logic [M-1:0][W-1:0] rd_b(input logic [0:0] a);
    logic [M-1:0][W-1:0] r;
    for (int m = 0; m < M; m++) r[m] = b_tab[int'(a)*M+m];
    return r;
  endfunction

  // Synchronous weight/bias memories: data appears the cycle after the address.
  always @(posedge clk) begin
    wd_r <= rd_w(wa_r);
    wd_i <= rd_w(wa_i);
    bd_r <= rd_b(ba_r);
    bd_i <= rd_b(ba_i);
  end

  function automatic vec_t fill(input logic [W-1:0] v);
    vec_t r;
    for (int i = 0; i < NN; i++) r[i] = v;
    return r;
  endfunction

  function automatic exp_t mk(input vec_t r, input vec_t i);
    exp_t e;
    e.relu = r;
    e.id   = i;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_all(input logic signed [W-1:0] w, input logic signed [W-1:0] b);
    for (int n = 0; n < NN; n++) begin
      b_tab[n] = b;
      for (int i = 0; i < N; i++) w_tab[n][i] = w;
    end
  endtask

  task automatic check_addr();
    int g, c;
    for (int k = 0; k < LAT; k++) begin
      @(negedge clk);
      g = k / (N + 2);
      c = k % (N + 2);
      if (c < N) begin
        chk("waddr_relu", 64'(wa_r), 64'(g * N + c));
        chk("waddr_id", 64'(wa_i), 64'(g * N + c));
      end
      if (c == 0) begin
        chk("baddr_relu", 64'(ba_r), 64'(g));
        chk("baddr_id", 64'(ba_i), 64'(g));
        chk("in_ready_busy", 64'(in_ready_r), 64'd0);
      end
    end
    @(negedge clk);
    chk("waddr_idle", 64'(wa_r), 64'd0);
    chk("baddr_idle", 64'(ba_r), 64'd0);
    chk("ovalid_on_time", 64'(ov_r), 64'd1);
  endtask

  task automatic wait_accept();
    int n = 0;
    @(negedge clk);
    while (!in_ready_r && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready_r) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: in_ready stayed 0, required 1");
    end
  endtask

  task automatic send(input ivec_t x, input exp_t e, input bit chk_addr);
    exp_q.push_back(e);
    @(posedge clk); #1;
    inputs   = x;
    in_valid = 1'b1;
    wait_accept();
    @(posedge clk); #1;
    in_valid = 1'b0;
    inputs   = '1;
    if (chk_addr) check_addr();
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_q.size() != 0 || ov_r) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
    end
  endtask

  // Monitor: pops one expectation per result and checks latency, values and stability.
  initial begin
    exp_t cur;
    bit seen = 1'b0, cur_ok = 1'b0, prev_hold = 1'b0;
    int t;
    cur = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        acc_t_q.delete();
        seen = 1'b0;
        prev_hold = 1'b0;
      end else begin
        if (in_valid && in_ready_r) acc_t_q.push_back(cyc + 1);
        if (ov_r && !seen) begin
          seen = 1'b1;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            cur_ok = 1'b0;
            $display("FAIL unexpected_valid: out_valid=1 with no vector pending, required 0");
          end else begin
            cur = exp_q.pop_front();
            cur_ok = 1'b1;
            if (acc_t_q.size() > 0) begin
              t = acc_t_q.pop_front();
              chk("latency", 64'(cyc), 64'(t + LAT));
            end else begin
              total++;
              bad++;
              $display("FAIL no_accept: result without an accept, required an accept first");
            end
          end
        end
        if (ov_r && cur_ok) begin
          chk("out_relu", outs_r, cur.relu);
          chk("out_id", outs_i, cur.id);
          chk("ovalid_id", 64'(ov_i), 64'd1);
        end
        if (prev_hold && !ov_r) begin
          total++;
          bad++;
          $display("FAIL ovalid_drop: out_valid=0 while stalled, required 1");
        end
        prev_hold = ov_r && !out_ready;
        if (ov_r && out_ready) seen = 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    ivec_t x1, xs, xt;
    vec_t  diag;
    int    n;
    x1[0] = 16'd256; x1[1] = 16'd512; x1[2] = 16'd768; x1[3] = 16'd1024;
    xs = {4{16'd25600}};
    xt = '0;
    xt[0] = 16'd1;
    diag[0] = 16'd512; diag[1] = 16'd1088; diag[2] = 16'd1664; diag[3] = 16'd2240;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; inputs = '0;
    set_all(16'sd0, 16'sd0);
    repeat (3) @(negedge clk);
    chk("rst_outs_relu", outs_r, 64'd0);
    chk("rst_outs_id", outs_i, 64'd0);
    chk("rst_ovalid", 64'(ov_r), 64'd0);
    chk("rst_waddr", 64'(wa_r), 64'd0);
    chk("rst_baddr", 64'(ba_r), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready_r), 64'd1);

    // 1 + 2 + 3 + 4 with unit weights plus 0.5 bias = 10.5
    set_all(16'sd256, 16'sd128);
    send(x1, mk(fill(16'd2688), fill(16'd2688)), 1'b1);
    wait_done();

    set_all(-16'sd256, 16'sd0);
    send(x1, mk(fill(16'd0), fill(16'hF600)), 1'b0);
    wait_done();

    set_all(16'sd25600, 16'sd0);
    send(xs, mk(fill(16'h7FFF), fill(16'h7FFF)), 1'b0);
    wait_done();

    set_all(-16'sd25600, 16'sd0);
    send(xs, mk(fill(16'd0), fill(16'h8000)), 1'b0);
    wait_done();

    // Diagonal weight 2.0 and bias 0.25*n: exposes lane, group and input-index mapping
    for (int nn = 0; nn < NN; nn++) begin
      b_tab[nn] = 16'(64 * nn);
      for (int i = 0; i < N; i++) w_tab[nn][i] = (nn == i) ? 16'sd512 : 16'sd0;
    end
    send(x1, mk(diag, diag), 1'b0);
    wait_done();

    // -1/65536 rounds toward minus infinity to -1 LSB
    set_all(-16'sd1, 16'sd0);
    send(xt, mk(fill(16'd0), fill(16'hFFFF)), 1'b0);
    wait_done();

    // Back-pressure with in_valid held high: result holds, no accept until released
    set_all(16'sd256, 16'sd128);
    out_ready = 1'b0;
    send(x1, mk(fill(16'd2688), fill(16'd2688)), 1'b0);
    exp_q.push_back(mk(fill(16'd2688), fill(16'd2688)));
    inputs = x1;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ov_r && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("hold_reached", 64'(ov_r), 64'd1);
    repeat (20) begin
      @(negedge clk);
      chk("hold_ovalid", 64'(ov_r), 64'd1);
      chk("hold_in_ready", 64'(in_ready_r), 64'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("release_ovalid", 64'(ov_r), 64'd0);
    chk("release_in_ready", 64'(in_ready_r), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    inputs = '1;
    wait_done();

    // Reset in group cycle 5 aborts the computation with no result
    @(posedge clk); #1;
    inputs = x1;
    in_valid = 1'b1;
    wait_accept();
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("abort_outs_relu", outs_r, 64'd0);
    chk("abort_outs_id", outs_i, 64'd0);
    chk("abort_ovalid", 64'(ov_r), 64'd0);
    chk("abort_waddr", 64'(wa_r), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_in_ready", 64'(in_ready_r), 64'd1);
    repeat (20) @(negedge clk);
    chk("abort_no_valid", 64'(ov_r), 64'd0);
    send(x1, mk(fill(16'd2688), fill(16'd2688)), 1'b0);
    wait_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
